slb_window_counter: RTL and testbench
=====================================

SLB_WINDOW_COUNTER -- requirements
Module: slb_window_counter

Interface
REQ-001 The block SHALL have parameter POOL_K, default 2, meaning pooling window size and stride (>=2).
REQ-002 The block SHALL have parameter IMG_W, default 28, meaning pixels per input line (>=POOL_K).
REQ-003 The block SHALL have parameter IMG_H, default 28, meaning lines per input frame (>=POOL_K).
REQ-004 The block SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low, sampled on rising clk.
REQ-006 The block SHALL have port start, input, 1 bit, pixel-valid strobe; each high cycle accepts one pixel.
REQ-007 The block SHALL have port clr, input, 1 bit, synchronous frame restart.
REQ-008 The block SHALL have port col, output, clog2(IMG_W) bits, column index of the pixel accepted on the current cycle.
REQ-009 The block SHALL have port row, output, clog2(IMG_H) bits, row index of the pixel accepted on the current cycle.
REQ-010 The block SHALL have port out, output, 1 bit, pool-window-complete strobe.
REQ-011 The block SHALL have port line_end, output, 1 bit, last-pixel-of-line strobe.
REQ-012 The block SHALL have port frame_done, output, 1 bit, last-pixel-of-frame strobe.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a frame is partially received.

Function
REQ-014 The block SHALL hold registered col, row, kc (0..POOL_K-1), kr (0..POOL_K-1) and a 2-state FSM {IDLE, RUN}.
REQ-015 col, row SHALL be driven directly from registers and change only on clock edges.
REQ-016 On each start=1, clr=0 cycle: col increments; at col=IMG_W-1 col wraps to 0 and row increments; at row=IMG_H-1 with col=IMG_W-1, row wraps to 0.
REQ-017 kc SHALL advance with col, wrap to 0 after POOL_K-1, and be forced to 0 when col wraps.
REQ-018 kr SHALL advance only on line wrap, wrap to 0 after POOL_K-1, and be forced to 0 when row wraps.
REQ-019 With start=0, all counters and FSM SHALL hold.
REQ-020 out SHALL be combinational: start & ~clr & kc==POOL_K-1 & kr==POOL_K-1 & col<WL & row<HL, with WL=(IMG_W/POOL_K)*POOL_K and HL=(IMG_H/POOL_K)*POOL_K (integer division).
REQ-021 Trailing columns/rows beyond WL/HL SHALL be counted but never raise out (partial windows dropped).
REQ-022 line_end SHALL be combinational: start & ~clr & col==IMG_W-1.
REQ-023 frame_done SHALL be combinational: start & ~clr & col==IMG_W-1 & row==IMG_H-1.
REQ-024 FSM IDLE->RUN on start=1 with clr=0 unless that pixel is also frame_done (single-pixel frame impossible given parameter limits).
REQ-025 FSM RUN->IDLE on frame_done or clr; otherwise stay.
REQ-026 busy SHALL equal (state==RUN).
REQ-027 clr=1 SHALL zero col, row, kc, kr and set IDLE on the next edge regardless of start; the coincident pixel is dropped and out, line_end, frame_done are 0 that cycle.
REQ-028 Back-to-back frames SHALL need no idle cycle: the pixel after frame_done is accepted as (0,0).

Reset
REQ-029 rst_n=0 at a rising edge SHALL set col=0, row=0, kc=0, kr=0, state=IDLE; busy=0 after that edge.
REQ-030 rst_n=0 SHALL take precedence over clr and start; out, line_end, frame_done SHALL be forced 0 while rst_n=0.
REQ-031 Reset mid-frame SHALL discard all progress; the next accepted pixel is (0,0).

Verification (bench overrides POOL_K=2, IMG_W=5, IMG_H=4)
REQ-032 Continuous start for 20 cycles -> out high on pixels (1,1),(3,1),(1,3),(3,3) only (col,row); line_end on col=4; frame_done on cycle 20; busy low after it.
REQ-033 start toggled 1,0,1,0 -> counters advance only on high cycles; out pattern identical to REQ-032 in accepted-pixel order.
REQ-034 clr with start=1 at pixel (2,1) -> no strobes that cycle; next accepted pixel is (0,0); busy=0 for one cycle.
REQ-035 rst_n low at pixel (3,2) with start=1 -> all strobes 0, col=row=0, busy=0 after edge.
REQ-036 Two frames back-to-back (40 continuous starts) -> frame_done on cycles 20 and 40; 8 out pulses total; busy stays 1 across the boundary except the IDLE edge after cycle 20 when start continues (RUN re-entered same edge).

Source files
------------

// File: rtl/slb_window_counter.sv
// Raster-scan pixel position tracker for a non-overlapping POOL_K x POOL_K pooling stage.
// Flags complete pool windows, line ends and frame ends for each accepted pixel.
module slb_window_counter #(
    parameter int POOL_K = 2,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clr,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     out,
    output logic                     line_end,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int KW = $clog2(POOL_K);
    // Largest multiples of POOL_K that fit; pixels past these only belong to partial windows.
    localparam int WL = (IMG_W / POOL_K) * POOL_K;
    localparam int HL = (IMG_H / POOL_K) * POOL_K;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(POOL_K - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic [KW-1:0] kc, kc_nxt;
    logic [KW-1:0] kr, kr_nxt;

    logic accept;
    logic col_last, row_last;

    assign accept   = rst_n & start & ~clr;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    assign line_end   = accept & col_last;
    assign frame_done = accept & col_last & row_last;
    assign out        = accept & (kc == K_LAST) & (kr == K_LAST)
                        & (32'(col) < WL) & (32'(row) < HL);
    assign busy       = (state == RUN);

    always_comb begin
        col_nxt   = col;
        row_nxt   = row;
        kc_nxt    = kc;
        kr_nxt    = kr;
        state_nxt = state;
        if (clr) begin
            col_nxt   = '0;
            row_nxt   = '0;
            kc_nxt    = '0;
            kr_nxt    = '0;
            state_nxt = IDLE;
        end else if (start) begin
            if (col_last) begin
                col_nxt = '0;
                kc_nxt  = '0;
                if (row_last) begin
                    row_nxt = '0;
                    kr_nxt  = '0;
                end else begin
                    row_nxt = row + RW'(1);
                    kr_nxt  = (kr == K_LAST) ? '0 : kr + KW'(1);
                end
            end else begin
                col_nxt = col + CW'(1);
                kc_nxt  = (kc == K_LAST) ? '0 : kc + KW'(1);
            end
            // A frame-ending pixel always leaves the block idle, from either state.
            if (col_last && row_last) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            kc    <= '0;
            kr    <= '0;
            state <= IDLE;
        end else begin
            col   <= col_nxt;
            row   <= row_nxt;
            kc    <= kc_nxt;
            kr    <= kr_nxt;
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_slb_window_counter.sv
// Scoreboard bench for slb_window_counter with a 5x4 image and 2x2 pooling.
// Stimulus pushes the expected outputs of each cycle; a monitor pops and compares.
module tb_slb_window_counter;

    localparam int POOL_K = 2;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
    localparam int NPIX   = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clr;
    logic [2:0] col;
    logic [1:0] row;
    logic       out;
    logic       line_end;
    logic       frame_done;
    logic       busy;

    typedef struct {
        int col;
        int row;
        bit out;
        bit le;
        bit fd;
        bit busy;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    // Bench-side frame position: index of the next pixel to be accepted, and expected busy.
    int idx = 0;
    bit bsy = 1'b0;

    slb_window_counter #(
        .POOL_K(POOL_K),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clr       (clr),
        .col       (col),
        .row       (row),
        .out       (out),
        .line_end  (line_end),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Window-completing pixels of a 5x4 image with 2x2 pooling, worked out by hand.
    function automatic bit is_out_pixel(input int c, input int r);
        return (c == 1 && r == 1) || (c == 3 && r == 1) ||
               (c == 1 && r == 3) || (c == 3 && r == 3);
    endfunction

    task automatic cyc(input bit st, input bit cl, input bit rn);
        exp_t e;
        bit   acc;
        @(posedge clk);
        #1;
        start = st;
        clr   = cl;
        rst_n = rn;
        acc    = st && !cl && rn;
        e.col  = idx % IMG_W;
        e.row  = idx / IMG_W;
        e.out  = acc && is_out_pixel(e.col, e.row);
        e.le   = acc && (e.col == IMG_W - 1);
        e.fd   = acc && (idx == NPIX - 1);
        e.busy = bsy;
        exp_q.push_back(e);
        if (!rn || cl) begin
            idx = 0;
            bsy = 1'b0;
        end else if (st) begin
            bsy = (idx != NPIX - 1);
            idx = (idx + 1) % NPIX;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("col",        int'(col),        e.col);
                chk("row",        int'(row),        e.row);
                chk("out",        int'(out),        int'(e.out));
                chk("line_end",   int'(line_end),   int'(e.le));
                chk("frame_done", int'(frame_done), int'(e.fd));
                chk("busy",       int'(busy),       int'(e.busy));
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);

        // Reset still asserted with start high: strobes must stay low.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);

        // One full frame of continuous pixels, then an idle cycle.
        repeat (NPIX) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Pixel strobe toggled every cycle across a whole frame.
        for (int i = 0; i < 2 * NPIX; i++) cyc(i % 2 == 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Frame restart while the pixel at (2,1) is offered.
        repeat (7) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);

        // Reset while the pixel at (3,2) is offered.
        repeat (13) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);

        // Two frames back to back with no idle cycle between them.
        repeat (2 * NPIX) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
